// File: rtl/flash_ctrl_pkg.sv
// rtl/flash_ctrl_pkg.sv - shared command codes, unlock constants, state types for the NOR flash controller
package flash_ctrl_pkg;

    localparam logic [3:0] CMD_READ         = 4'd1;
    localparam logic [3:0] CMD_RESET        = 4'd2;
    localparam logic [3:0] CMD_PROGRAM      = 4'd3;
    localparam logic [3:0] CMD_CHIP_ERASE   = 4'd4;
    localparam logic [3:0] CMD_SECTOR_ERASE = 4'd5;
    localparam logic [3:0] CMD_SUSPEND      = 4'd6;
    localparam logic [3:0] CMD_RESUME       = 4'd7;

    localparam logic [22:0] ADDR_555 = 23'h000555;
    localparam logic [22:0] ADDR_2AA = 23'h0002AA;

    localparam logic [15:0] D_AA = 16'h00AA;
    localparam logic [15:0] D_55 = 16'h0055;
    localparam logic [15:0] D_A0 = 16'h00A0;
    localparam logic [15:0] D_80 = 16'h0080;
    localparam logic [15:0] D_10 = 16'h0010;
    localparam logic [15:0] D_30 = 16'h0030;
    localparam logic [15:0] D_F0 = 16'h00F0;
    localparam logic [15:0] D_B0 = 16'h00B0;

    typedef enum logic [2:0] {
        ST_IDLE, ST_W_SU, ST_W_WP, ST_W_WPH, ST_R_ACC, ST_ACK
    } bus_state_t;

    typedef enum logic [1:0] {
        SQ_IDLE, SQ_RUN, SQ_BUSY
    } seq_state_t;

    // Zero marks a code the sequencer must ignore.
    function automatic logic [2:0] cycle_count(input logic [3:0] code);
        case (code)
            CMD_READ, CMD_RESET, CMD_SUSPEND, CMD_RESUME: return 3'd1;
            CMD_PROGRAM:                                  return 3'd4;
            CMD_CHIP_ERASE, CMD_SECTOR_ERASE:             return 3'd6;
            default:                                      return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/flash_bus_cycle.sv
// rtl/flash_bus_cycle.sv - one timed NOR bus cycle (write SU/WP/WPH or read ACC) with registered strobes
module flash_bus_cycle
    import flash_ctrl_pkg::*;
#(
    parameter int T_SU  = 1,
    parameter int T_WP  = 3,
    parameter int T_WPH = 2,
    parameter int T_ACC = 5
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        go_i,
    input  logic        write_i,
    input  logic [22:0] addr_i,
    input  logic [15:0] data_i,
    input  logic [15:0] mem_dq_i,
    output logic        done_o,
    output logic        ack_o,
    output logic [15:0] readdata_o,
    output logic [22:0] mem_addr_o,
    output logic [15:0] mem_dq_o,
    output logic        mem_dq_oe_o,
    output logic        mem_ce_n_o,
    output logic        mem_oe_n_o,
    output logic        mem_we_n_o
);

    bus_state_t state;
    logic [7:0] cnt;

    // Final cycle of the active phase; lets the sequencer queue the next cycle during ACK.
    always_comb begin
        done_o = ((state == ST_W_WPH) && (cnt == 8'(T_WPH - 1))) ||
                 ((state == ST_R_ACC) && (cnt == 8'(T_ACC - 1)));
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            ack_o       <= 1'b0;
            readdata_o  <= '0;
            mem_addr_o  <= '0;
            mem_dq_o    <= '0;
            mem_dq_oe_o <= 1'b0;
            mem_ce_n_o  <= 1'b1;
            mem_oe_n_o  <= 1'b1;
            mem_we_n_o  <= 1'b1;
        end else begin
            ack_o <= 1'b0;
            cnt   <= cnt + 8'd1;
            case (state)
                ST_IDLE, ST_ACK: begin
                    state <= ST_IDLE;
                    if (go_i) begin
                        cnt        <= '0;
                        mem_addr_o <= addr_i;
                        mem_ce_n_o <= 1'b0;
                        if (write_i) begin
                            state       <= ST_W_SU;
                            mem_dq_o    <= data_i;
                            mem_dq_oe_o <= 1'b1;
                        end else begin
                            state      <= ST_R_ACC;
                            mem_oe_n_o <= 1'b0;
                        end
                    end
                end
                ST_W_SU: if (cnt == 8'(T_SU - 1)) begin
                    state      <= ST_W_WP;
                    mem_we_n_o <= 1'b0;
                    cnt        <= '0;
                end
                ST_W_WP: if (cnt == 8'(T_WP - 1)) begin
                    state      <= ST_W_WPH;
                    mem_we_n_o <= 1'b1;
                    cnt        <= '0;
                end
                ST_W_WPH: if (done_o) begin
                    state       <= ST_ACK;
                    mem_ce_n_o  <= 1'b1;
                    mem_dq_oe_o <= 1'b0;
                    ack_o       <= 1'b1;
                end
                ST_R_ACC: if (done_o) begin
                    state      <= ST_ACK;
                    mem_ce_n_o <= 1'b1;
                    mem_oe_n_o <= 1'b1;
                    readdata_o <= mem_dq_i;
                    ack_o      <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/flash_cmd_sequencer.sv
// rtl/flash_cmd_sequencer.sv - expands register-block commands into JEDEC NOR bus-cycle sequences
module flash_cmd_sequencer
    import flash_ctrl_pkg::*;
#(
    parameter int T_SU   = 1,
    parameter int T_WP   = 3,
    parameter int T_WPH  = 2,
    parameter int T_ACC  = 5,
    parameter int T_BUSY = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [3:0]  code_i,
    input  logic [6:0]  block_addr_i,
    input  logic [15:0] other_addr_i,
    input  logic [15:0] dq_data_i,
    input  logic [15:0] mem_dq_i,
    input  logic        mem_ry_by_n_i,
    output logic        ack_o,
    output logic [15:0] readdata_o,
    output logic        busy_o,
    output logic [22:0] mem_addr_o,
    output logic [15:0] mem_dq_o,
    output logic        mem_dq_oe_o,
    output logic        mem_ce_n_o,
    output logic        mem_oe_n_o,
    output logic        mem_we_n_o
);

    seq_state_t  state;
    logic        start_q, go, last_q, done;
    logic [2:0]  idx, count;
    logic [3:0]  code;
    logic [6:0]  block;
    logic [15:0] other, wdata;
    logic [7:0]  bcnt;
    logic [22:0] sel_addr;
    logic [15:0] sel_data;

    assign count = cycle_count(code);

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        case (code)
            CMD_READ:    sel_addr = {block, other};
            CMD_RESET:   sel_data = D_F0;
            CMD_SUSPEND: sel_data = D_B0;
            CMD_RESUME:  sel_data = D_30;
            CMD_PROGRAM: case (idx)
                3'd0:    begin sel_addr = ADDR_555; sel_data = D_AA; end
                3'd1:    begin sel_addr = ADDR_2AA; sel_data = D_55; end
                3'd2:    begin sel_addr = ADDR_555; sel_data = D_A0; end
                default: begin sel_addr = {block, other}; sel_data = wdata; end
            endcase
            CMD_CHIP_ERASE, CMD_SECTOR_ERASE: case (idx)
                3'd0, 3'd3: begin sel_addr = ADDR_555; sel_data = D_AA; end
                3'd1, 3'd4: begin sel_addr = ADDR_2AA; sel_data = D_55; end
                3'd2:       begin sel_addr = ADDR_555; sel_data = D_80; end
                default: begin
                    if (code == CMD_CHIP_ERASE) begin
                        sel_addr = ADDR_555; sel_data = D_10;
                    end else begin
                        sel_addr = {block, 16'h0000}; sel_data = D_30;
                    end
                end
            endcase
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state   <= SQ_IDLE;
            start_q <= 1'b0;
            go      <= 1'b0;
            last_q  <= 1'b0;
            idx     <= '0;
            code    <= '0;
            block   <= '0;
            other   <= '0;
            wdata   <= '0;
            bcnt    <= '0;
            busy_o  <= 1'b0;
        end else begin
            start_q <= start_i;
            go      <= 1'b0;
            case (state)
                SQ_IDLE: if (start_i && !start_q && mem_ry_by_n_i &&
                             cycle_count(code_i) != 3'd0) begin
                    state  <= SQ_RUN;
                    go     <= 1'b1;
                    idx    <= '0;
                    last_q <= 1'b0;
                    busy_o <= 1'b1;
                    code   <= code_i;
                    block  <= block_addr_i;
                    other  <= other_addr_i;
                    wdata  <= dq_data_i;
                end
                SQ_RUN: begin
                    // The next cycle is launched while the bus cycle sits in ACK, keeping cycles back-to-back.
                    if (done) begin
                        last_q <= (idx == count - 3'd1);
                        if (idx != count - 3'd1) begin
                            idx <= idx + 3'd1;
                            go  <= 1'b1;
                        end
                    end
                    if (ack_o && last_q) begin
                        bcnt <= '0;
                        if (code == CMD_PROGRAM || code == CMD_CHIP_ERASE ||
                            code == CMD_SECTOR_ERASE) begin
                            state <= SQ_BUSY;
                        end else begin
                            state  <= SQ_IDLE;
                            busy_o <= 1'b0;
                        end
                    end
                end
                SQ_BUSY: begin
                    if (bcnt != 8'(T_BUSY)) begin
                        bcnt <= bcnt + 8'd1;
                    end else if (mem_ry_by_n_i) begin
                        state  <= SQ_IDLE;
                        busy_o <= 1'b0;
                    end
                end
                default: state <= SQ_IDLE;
            endcase
        end
    end

    flash_bus_cycle #(
        .T_SU (T_SU),
        .T_WP (T_WP),
        .T_WPH(T_WPH),
        .T_ACC(T_ACC)
    ) u_bus_cycle (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .go_i       (go),
        .write_i    (code != CMD_READ),
        .addr_i     (sel_addr),
        .data_i     (sel_data),
        .mem_dq_i   (mem_dq_i),
        .done_o     (done),
        .ack_o      (ack_o),
        .readdata_o (readdata_o),
        .mem_addr_o (mem_addr_o),
        .mem_dq_o   (mem_dq_o),
        .mem_dq_oe_o(mem_dq_oe_o),
        .mem_ce_n_o (mem_ce_n_o),
        .mem_oe_n_o (mem_oe_n_o),
        .mem_we_n_o (mem_we_n_o)
    );

endmodule

// File: tb/tb_flash_cmd_sequencer.sv
// tb/tb_flash_cmd_sequencer.sv - directed self-checking bench for flash_cmd_sequencer
module tb_flash_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        start_i = 1'b0;
    logic [3:0]  code_i = '0;
    logic [6:0]  block_addr_i = '0;
    logic [15:0] other_addr_i = '0;
    logic [15:0] dq_data_i = '0;
    logic [15:0] mem_dq_i = '0;
    logic        mem_ry_by_n_i = 1'b1;
    logic        ack_o, busy_o, mem_dq_oe_o, mem_ce_n_o, mem_oe_n_o, mem_we_n_o;
    logic [15:0] readdata_o, mem_dq_o;
    logic [22:0] mem_addr_o;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int n_start;

    logic [31:0] ack_q[$], wa_q[$], wd_q[$], we_len_q[$], ra_q[$], oe_len_q[$];
    int we_run = 0, oe_run = 0, ce_low = 0, busy_hi = 0;

    flash_cmd_sequencer dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .code_i       (code_i),
        .block_addr_i (block_addr_i),
        .other_addr_i (other_addr_i),
        .dq_data_i    (dq_data_i),
        .mem_dq_i     (mem_dq_i),
        .mem_ry_by_n_i(mem_ry_by_n_i),
        .ack_o        (ack_o),
        .readdata_o   (readdata_o),
        .busy_o       (busy_o),
        .mem_addr_o   (mem_addr_o),
        .mem_dq_o     (mem_dq_o),
        .mem_dq_oe_o  (mem_dq_oe_o),
        .mem_ce_n_o   (mem_ce_n_o),
        .mem_oe_n_o   (mem_oe_n_o),
        .mem_we_n_o   (mem_we_n_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ack_o) ack_q.push_back(32'(cyc));
        if (!mem_we_n_o) begin
            we_run++;
            if (we_run == 1) begin
                wa_q.push_back(32'(mem_addr_o));
                wd_q.push_back(32'(mem_dq_o));
            end
        end else if (we_run != 0) begin
            we_len_q.push_back(32'(we_run));
            we_run = 0;
        end
        if (!mem_oe_n_o) begin
            oe_run++;
            if (oe_run == 1) ra_q.push_back(32'(mem_addr_o));
        end else if (oe_run != 0) begin
            oe_len_q.push_back(32'(oe_run));
            oe_run = 0;
        end
        if (!mem_ce_n_o) ce_low++;
        if (busy_o) busy_hi++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_mon();
        ack_q.delete(); wa_q.delete(); wd_q.delete(); we_len_q.delete();
        ra_q.delete(); oe_len_q.delete();
        ce_low = 0; busy_hi = 0;
    endtask

    task automatic issue(input logic [3:0] c, input logic [6:0] b, input logic [15:0] o,
                         input logic [15:0] d);
        code_i = c; block_addr_i = b; other_addr_i = o; dq_data_i = d;
        start_i = 1'b1;
        n_start = cyc + 1;
        step();
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k = 0;
        while (busy_o && k < budget) begin
            step();
            k++;
        end
        check(tag, 32'(busy_o), 32'd0);
    endtask

    initial begin
        logic [31:0] pa[4];
        logic [31:0] pd[4];
        int snap, k;
        pa = '{32'h555, 32'h2AA, 32'h555, 32'h000040};
        pd = '{32'h00AA, 32'h0055, 32'h00A0, 32'hA5A5};

        step(3);
        check("rst_ce_n", 32'(mem_ce_n_o), 32'd1);
        check("rst_oe_n", 32'(mem_oe_n_o), 32'd1);
        check("rst_we_n", 32'(mem_we_n_o), 32'd1);
        check("rst_ack", 32'(ack_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_readdata", 32'(readdata_o), 32'd0);
        check("rst_dq_oe", 32'(mem_dq_oe_o), 32'd0);
        rst_i = 1'b1;
        step(2);

        clear_mon();
        mem_dq_i = 16'hBEEF;
        issue(4'd1, 7'h03, 16'h1234, 16'h0000);
        wait_idle("read_timeout", 100);
        start_i = 1'b0;
        check("read_acks", 32'(ack_q.size()), 32'd1);
        if (ack_q.size() > 0) check("read_ack_lat", ack_q[0] - 32'(n_start), 32'd6);
        check("read_data", 32'(readdata_o), 32'hBEEF);
        if (ra_q.size() > 0) check("read_addr", ra_q[0], 32'h031234);
        if (oe_len_q.size() > 0) check("read_oe_len", oe_len_q[0], 32'd5);
        check("read_no_we", 32'(wa_q.size()), 32'd0);
        step(2);

        clear_mon();
        issue(4'd3, 7'h00, 16'h0040, 16'hA5A5);
        mem_ry_by_n_i = 1'b0;
        k = 0;
        while (ack_q.size() < 4 && k < 200) begin step(); k++; end
        check("prog_acks", 32'(ack_q.size()), 32'd4);
        start_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (ack_q.size() > i) check("prog_ack_time", ack_q[i] - 32'(n_start), 32'(7 * (i + 1)));
            if (wa_q.size() > i) check("prog_addr", wa_q[i], pa[i]);
            if (wd_q.size() > i) check("prog_data", wd_q[i], pd[i]);
            if (we_len_q.size() > i) check("prog_we_len", we_len_q[i], 32'd3);
        end
        step(20);
        check("prog_busy_hold", 32'(busy_o), 32'd1);
        mem_ry_by_n_i = 1'b1;
        step();
        check("prog_busy_drop", 32'(busy_o), 32'd0);
        step(2);

        clear_mon();
        issue(4'd5, 7'h12, 16'hFFFF, 16'h0000);
        wait_idle("se_timeout", 200);
        start_i = 1'b0;
        check("se_acks", 32'(ack_q.size()), 32'd6);
        if (wa_q.size() > 5) check("se_last_addr", wa_q[5], 32'h120000);
        if (wd_q.size() > 5) check("se_last_data", wd_q[5], 32'h0030);
        if (wa_q.size() > 2) check("se_3rd_addr", wa_q[2], 32'h555);
        if (wd_q.size() > 2) check("se_3rd_data", wd_q[2], 32'h0080);
        step(2);

        clear_mon();
        issue(4'd9, 7'h00, 16'h0000, 16'h0000);
        step(15);
        start_i = 1'b0;
        check("inv_acks", 32'(ack_q.size()), 32'd0);
        check("inv_ce", 32'(ce_low), 32'd0);
        check("inv_busy", 32'(busy_hi), 32'd0);
        step(2);

        clear_mon();
        mem_ry_by_n_i = 1'b0;
        issue(4'd2, 7'h00, 16'h0000, 16'h0000);
        step(15);
        start_i = 1'b0;
        mem_ry_by_n_i = 1'b1;
        check("blk_acks", 32'(ack_q.size()), 32'd0);
        check("blk_busy", 32'(busy_hi), 32'd0);
        step(3);
        check("blk_discard", 32'(busy_o), 32'd0);

        clear_mon();
        issue(4'd2, 7'h00, 16'h0000, 16'h0000);
        step(39);
        start_i = 1'b0;
        step(5);
        check("held_acks", 32'(ack_q.size()), 32'd1);
        check("held_writes", 32'(wa_q.size()), 32'd1);
        if (wa_q.size() > 0) check("held_addr", wa_q[0], 32'h0);
        if (wd_q.size() > 0) check("held_data", wd_q[0], 32'h00F0);

        clear_mon();
        issue(4'd3, 7'h00, 16'h0040, 16'h1234);
        k = 0;
        while (!(ack_q.size() == 1 && !mem_we_n_o) && k < 200) begin step(); k++; end
        check("abort_in_wp", 32'(mem_we_n_o), 32'd0);
        rst_i = 1'b0;
        start_i = 1'b0;
        step();
        check("abort_we_n", 32'(mem_we_n_o), 32'd1);
        check("abort_ce_n", 32'(mem_ce_n_o), 32'd1);
        check("abort_busy", 32'(busy_o), 32'd0);
        rst_i = 1'b1;
        snap = ce_low;
        step(30);
        check("abort_acks", 32'(ack_q.size()), 32'd1);
        check("abort_idle_ce", 32'(ce_low - snap), 32'd0);
        check("abort_idle_busy", 32'(busy_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/flash_cmd_sequencer.md
# flash_cmd_sequencer

Flash command sequencer that sits directly downstream of the Avalon slave register block. It consumes the latched command code, block and other address, TX data and the `start` level. It expands each command into the JEDEC/AMD-style bus-cycle sequence on the parallel NOR flash pins (CE#/OE#/WE#, address, DQ), with programmable cycle timing. It returns one `ack_o` pulse per completed bus cycle and the captured read word.

## Interface
- `T_SU`, default 1: cycles CE# low with address/data stable before WE# falls (min 1).
- `T_WP`, default 3: WE# low width in cycles (min 1).
- `T_WPH`, default 2: WE# high hold after rising edge, CE# still low (min 1).
- `T_ACC`, default 5: CE#/OE# low cycles before read capture (min 1).
- `T_BUSY`, default 4: cycles ignored after the last program/erase write before sampling `mem_ry_by_n_i`.
- `clk_i` in 1: single clock.
- `rst_i` in 1: reset, synchronous, active-low.
- `start_i` in 1: command request level from the slave.
- `code_i` in 4: command code.
- `block_addr_i` in 7: sector/block address, A[22:16].
- `other_addr_i` in 16: in-block word address, A[15:0].
- `dq_data_i` in 16: program data.
- `mem_dq_i` in 16: flash DQ input.
- `mem_ry_by_n_i` in 1: flash ready (1) / busy (0).
- `ack_o` out 1: one-cycle pulse per completed bus cycle.
- `readdata_o` out 16: last captured read word.
- `busy_o` out 1: high from accepted start until return to IDLE.
- `mem_addr_o` out 23: flash address.
- `mem_dq_o` out 16: flash write data.
- `mem_dq_oe_o` out 1: DQ output enable.
- `mem_ce_n_o`, `mem_oe_n_o`, `mem_we_n_o` out 1 each: flash strobes, active-low.

## Operation
**Commands**
- `start_i` is edge-detected (`start_i & ~start_q`). A command is accepted only in IDLE with `mem_ry_by_n_i`=1. A level held across acks never retriggers.
- Code 1, READ: one read cycle at `{block,other}`. 1 ack.
- Code 2, RESET: write F0 to 0x000. 1 ack.
- Code 3, PROGRAM: 555/AA, 2AA/55, 555/A0, then `{block,other}`/`dq_data_i`. 4 acks.
- Code 4, CHIP ERASE: 555/AA, 2AA/55, 555/80, 555/AA, 2AA/55, 555/10. 6 acks.
- Code 5, SECTOR ERASE: same as code 4, but the last cycle is `{block,16'h0}`/30. 6 acks.
- Code 6, ERASE SUSPEND: write B0 to 0x000. 1 ack.
- Code 7, ERASE RESUME: write 30 to 0x000. 1 ack.
- Codes 0 and 8–15: ignored. No ack, busy_o stays 0.
- Unlock addresses have all other address bits zero.
- Inputs are sampled every cycle. The team's slave holds them stable while `start_i` is high.

**States**
- IDLE: on an accepted start go to W_SU or R_ACC, and set the cycle index to 0.
- W_SU (T_SU cycles): CE#=0, WE#=1, OE#=1, addr/data driven, dq_oe=1. Then W_WP.
- W_WP (T_WP cycles): WE#=0. Then W_WPH.
- W_WPH (T_WPH cycles): WE#=1, CE#=0. Then ACK.
- R_ACC (T_ACC cycles): CE#=0, OE#=0, dq_oe=0. `readdata_o` <= `mem_dq_i` on the last cycle. Then ACK.
- ACK (1 cycle): `ack_o`=1, all strobes high, dq_oe=0.
  - If this is the last cycle of a code 3/4/5 command, go to BUSY.
  - Else if more cycles remain, increment the index and go to W_SU.
  - Else go to IDLE.
- BUSY: wait T_BUSY cycles, then until `mem_ry_by_n_i`=1, then go to IDLE. `busy_o`=1 throughout.

**Reset**
- On reset: ce_n=oe_n=we_n=1, dq_oe=0, ack=0, busy=0, addr=0, dq=0, readdata=0, state=IDLE, start_q=0.
- Reset mid-sequence aborts on the next edge. Strobes return high that same cycle, and no further ack is issued.

## Timing
- Start rising at edge N is detected at N; the first W_SU/R_ACC cycle is N+1.
- Write bus cycle length = T_SU+T_WP+T_WPH+1. With defaults this is 7 cycles, so PROGRAM acks land at +7, +14, +21, +28.
- Read: ack at N+T_ACC+1, i.e. N+6 with defaults. `readdata_o` is valid from the ack cycle and holds until the next read.
- Back-to-back cycles always pass through ACK, so CE# is high for at least 1 cycle between cycles.
- All outputs are registered. No combinational path from inputs to mem_* pins.
- If `mem_ry_by_n_i` is low in IDLE when start rises, the start is discarded. Software must retry.

## Structure
- `flash_ctrl_pkg` holds:
  - command code localparams 1–7;
  - unlock addresses 23'h555 and 23'h2AA;
  - data constants AA/55/A0/80/10/30/F0/B0;
  - the state enum;
  - a per-code cycle-count function (1/1/4/6/6/1/1).
- One sub-module, `flash_bus_cycle`, contains the SU/WP/WPH/ACC timer and strobe generation for a single cycle. It has a start/done handshake.
- The sequencer selects the addr/data per index and counts cycles.

## Test plan
- **Reset:** reset asserted for 3 cycles → ce_n/oe_n/we_n=1, ack=0, busy=0, readdata=0.
- **READ:** code 1, block 7'h03, other 16'h1234, mem_dq_i=16'hBEEF → addr 23'h031234, OE# low 5 cycles, one ack at N+6, readdata=BEEF.
- **PROGRAM:** code 3, block 0, other 16'h0040, data 16'hA5A5 → 4 acks spaced 7 cycles apart.
  - Writes 555/AA, 2AA/55, 555/A0, 000040/A5A5; WE# low exactly 3 cycles each.
  - Then BUSY holds while RY/BY#=0 for 20 cycles; busy_o drops 1 cycle after it goes high.
- **SECTOR ERASE:** code 5, block 7'h12 → 6 acks; last write addr 23'h120000, data 0030.
- **Invalid/blocked:** code 9 with start → no strobes, no ack. Code 2 while RY/BY#=0 → discarded. `start_i` held high 40 cycles → exactly one sequence.
- **Abort:** reset asserted during W_WP of the 2nd PROGRAM cycle → WE#/CE# high next cycle, no more acks, IDLE.
